// File: rtl/compare_result_debouncer.sv
// Purpose : debounce the one-hot greater/equal/less flags of a magnitude comparator into a stable relation code.
// Latency : relation_out, change_pulse_out and illegal_out update one cycle after the deciding sample.
// Backpres: none; a sample is consumed on every cycle valid_in is high, and idle cycles hold all state.
//
// Ports:
//   clk_in, rst_n_in            clock (rising edge) and asynchronous active-low reset
//   valid_in                    comparator flags are sampled this cycle
//   a_in_g_b_in/e_b_in/l_b_in   comparator flags: greater / equal / less
//   clear_in                    synchronous clear of all state, wins over valid_in
//   relation_out                00 UNKNOWN, 01 LESS, 10 EQUAL, 11 GREATER
//   relation_valid_out          relation_out holds a real relation
//   change_pulse_out            one-cycle pulse when relation_out changes
//   illegal_out                 one-cycle pulse for a valid, non-one-hot sample
//   gt/eq/lt_count_out          saturating counts of legal samples per relation
module compare_result_debouncer #(
    parameter int DEBOUNCE_CNT = 3,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 valid_in,
    input  logic                 a_in_g_b_in,
    input  logic                 a_in_e_b_in,
    input  logic                 a_in_l_b_in,
    input  logic                 clear_in,
    output logic [1:0]           relation_out,
    output logic                 relation_valid_out,
    output logic                 change_pulse_out,
    output logic                 illegal_out,
    output logic [CNT_WIDTH-1:0] gt_count_out,
    output logic [CNT_WIDTH-1:0] eq_count_out,
    output logic [CNT_WIDTH-1:0] lt_count_out
);

    // Relation encoding shared by the candidate and the published relation.
    localparam logic [1:0] REL_UNKNOWN = 2'b00;
    localparam logic [1:0] REL_LESS    = 2'b01;
    localparam logic [1:0] REL_EQUAL   = 2'b10;
    localparam logic [1:0] REL_GREATER = 2'b11;

    // Run length fits in 4 bits because DEBOUNCE_CNT is limited to 1..15.
    localparam logic [3:0]           RUN_TARGET = 4'(DEBOUNCE_CNT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

    typedef enum logic {
        ST_UNKNOWN  = 1'b0,
        ST_TRACKING = 1'b1
    } state_t;

    state_t               state_q;
    logic [1:0]           relation_q;
    logic [1:0]           candidate_q;
    logic [3:0]           run_q;
    logic                 change_pulse_q;
    logic                 illegal_q;
    logic [CNT_WIDTH-1:0] gt_count_q;
    logic [CNT_WIDTH-1:0] eq_count_q;
    logic [CNT_WIDTH-1:0] lt_count_q;

    logic [1:0] flag_sum;
    logic       sample_legal;
    logic [1:0] sample_code;
    logic [1:0] candidate_next;
    logic [3:0] run_next;
    logic       relation_update;
    logic       gt_inc;
    logic       eq_inc;
    logic       lt_inc;

    // Sample classification: legal only when exactly one flag is set.
    always_comb begin
        flag_sum     = {1'b0, a_in_g_b_in} + {1'b0, a_in_e_b_in} + {1'b0, a_in_l_b_in};
        sample_legal = (flag_sum == 2'd1);
        sample_code  = REL_UNKNOWN;
        if (a_in_g_b_in) begin
            sample_code = REL_GREATER;
        end else if (a_in_e_b_in) begin
            sample_code = REL_EQUAL;
        end else if (a_in_l_b_in) begin
            sample_code = REL_LESS;
        end
    end

    // Candidate / run tracking. Idle cycles hold the run, so gaps in
    // valid_in do not break a sequence of identical samples.
    always_comb begin
        candidate_next = candidate_q;
        run_next       = run_q;
        if (valid_in) begin
            if (!sample_legal) begin
                candidate_next = REL_UNKNOWN;
                run_next       = 4'd0;
            end else if (sample_code == candidate_q) begin
                run_next = (run_q == RUN_TARGET) ? RUN_TARGET : run_q + 4'd1;
            end else begin
                candidate_next = sample_code;
                run_next       = 4'd1;
            end
        end
    end

    // The relation moves on the very edge the run completes. Once the run has
    // saturated, relation already equals the candidate, so further identical
    // samples never re-trigger a change pulse.
    always_comb begin
        relation_update = valid_in && sample_legal &&
                          (run_next == RUN_TARGET) &&
                          (candidate_next != relation_q);
    end

    // Occurrence counter enables; each sticks at all-ones independently.
    always_comb begin
        gt_inc = valid_in && sample_legal && (sample_code == REL_GREATER) && (gt_count_q != CNT_MAX);
        eq_inc = valid_in && sample_legal && (sample_code == REL_EQUAL)   && (eq_count_q != CNT_MAX);
        lt_inc = valid_in && sample_legal && (sample_code == REL_LESS)    && (lt_count_q != CNT_MAX);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q        <= ST_UNKNOWN;
            relation_q     <= REL_UNKNOWN;
            candidate_q    <= REL_UNKNOWN;
            run_q          <= 4'd0;
            change_pulse_q <= 1'b0;
            illegal_q      <= 1'b0;
            gt_count_q     <= '0;
            eq_count_q     <= '0;
            lt_count_q     <= '0;
        end else if (clear_in) begin
            // Clear discards any simultaneous sample and never pulses.
            state_q        <= ST_UNKNOWN;
            relation_q     <= REL_UNKNOWN;
            candidate_q    <= REL_UNKNOWN;
            run_q          <= 4'd0;
            change_pulse_q <= 1'b0;
            illegal_q      <= 1'b0;
            gt_count_q     <= '0;
            eq_count_q     <= '0;
            lt_count_q     <= '0;
        end else begin
            candidate_q    <= candidate_next;
            run_q          <= run_next;
            change_pulse_q <= relation_update;
            illegal_q      <= valid_in && !sample_legal;

            if (relation_update) begin
                relation_q <= candidate_next;
            end

            // Illegal samples leave the state alone; only clear/reset
            // bring the tracker back to UNKNOWN.
            case (state_q)
                ST_UNKNOWN: begin
                    if (relation_update) begin
                        state_q <= ST_TRACKING;
                    end
                end
                ST_TRACKING: begin
                    state_q <= ST_TRACKING;
                end
                default: begin
                    state_q <= ST_UNKNOWN;
                end
            endcase

            if (gt_inc) begin
                gt_count_q <= gt_count_q + CNT_ONE;
            end
            if (eq_inc) begin
                eq_count_q <= eq_count_q + CNT_ONE;
            end
            if (lt_inc) begin
                lt_count_q <= lt_count_q + CNT_ONE;
            end
        end
    end

    assign relation_out       = relation_q;
    assign relation_valid_out = (state_q == ST_TRACKING);
    assign change_pulse_out   = change_pulse_q;
    assign illegal_out        = illegal_q;
    assign gt_count_out       = gt_count_q;
    assign eq_count_out       = eq_count_q;
    assign lt_count_out       = lt_count_q;

endmodule
